// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter that shares one BITS_COUNT-wide storage register among NUM_REQ requesters.
// After each load the register is held for HOLD_CYCLES cycles before the next grant.
module dff_share_arbiter #(
  parameter int BITS_COUNT  = 8,
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*BITS_COUNT-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [BITS_COUNT-1:0]            q,
  output logic                             q_valid,
  output logic [$clog2(NUM_REQ)-1:0]       q_owner,
  output logic                             busy
);

  localparam int OW = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t                state_q, state_d;
  logic [OW-1:0]         ptr_q, ptr_d;
  logic [7:0]            hold_cnt_q, hold_cnt_d;
  logic [BITS_COUNT-1:0] q_q, q_d;
  logic                  q_valid_q, q_valid_d;
  logic [OW-1:0]         q_owner_q, q_owner_d;

  logic [NUM_REQ-1:0]    rotated;
  logic                  found;
  int                    offset;
  int                    winner;
  logic [BITS_COUNT-1:0] win_data;
  logic [NUM_REQ-1:0]    win_onehot;

  // Rotate the request vector so bit 0 is the requester at ptr; the lowest set bit wins.
  always_comb begin
    rotated    = NUM_REQ'({req_valid, req_valid} >> ptr_q);
    found      = 1'b0;
    offset     = 0;
    winner     = 0;
    win_data   = '0;
    win_onehot = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        found  = 1'b1;
        offset = k;
      end
    end
    winner = int'(ptr_q) + offset;
    if (winner >= NUM_REQ) begin
      winner = winner - NUM_REQ;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i == winner) begin
        win_data      = req_data[i*BITS_COUNT +: BITS_COUNT];
        win_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    q_d        = q_q;
    q_valid_d  = q_valid_q;
    q_owner_d  = q_owner_q;
    req_ready  = '0;

    case (state_q)
      IDLE: begin
        if (found && !rst) begin
          req_ready = win_onehot;
          q_d       = win_data;
          q_owner_d = OW'(winner);
          q_valid_d = 1'b1;
          ptr_d     = (winner == NUM_REQ - 1) ? '0 : OW'(winner + 1);
          if (HOLD_CYCLES > 0) begin
            state_d    = HOLD;
            hold_cnt_d = 8'(HOLD_CYCLES - 1);
          end
        end
      end
      HOLD: begin
        if (hold_cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset wins over any handshake in the same cycle and aborts a hold in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= 8'd0;
      q_q        <= '0;
      q_valid_q  <= 1'b0;
      q_owner_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      q_q        <= q_d;
      q_valid_q  <= q_valid_d;
      q_owner_q  <= q_owner_d;
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign q_owner = q_owner_q;
  assign busy    = (state_q == HOLD);

endmodule
